pixel_ram_loader: RTL and testbench

Writable 16-entry × 4-bit pixel store for the 4×4 image convolution datapath. It is the write-side counterpart of the fixed pixel ROM. A source streams one frame of 16 pixels over a valid/ready handshake, and the store fills addresses 0..15 in raster order. The convolution core reads the frame through a combinational address/data port that behaves the same as the ROM. A random-access write port lets a filled frame be patched or overwritten with results.

---
 rtl/pixel_ram_loader_if.sv | 44 ++++
 rtl/pixel_ram_loader.sv | 138 +++++++++++++
 tb/tb_pixel_ram_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_ram_loader_if.sv
// -----------------------------------------------------------------------------
// pixel_ram_loader_if
// Bundles the stream, random-access write, read and status signals of the
// 16 x 4-bit pixel store.
//   slave  modport : used by the pixel store itself
//   master modport : used by whatever drives the store (source / core / bench)
// Signals:
//   start      one-cycle request to begin a new frame
//   in_valid   source presents a pixel on in_data
//   in_data    pixel value
//   in_ready   store accepts a pixel this cycle (registered)
//   wr_en      random-access write strobe
//   wr_address random-access write address
//   wr_data    random-access write data
//   address    read address (ROM-compatible)
//   data       read data = mem[address], combinational
//   busy       frame load in progress
//   done       frame complete
//   count      pixels accepted in the current frame, 0..16
// -----------------------------------------------------------------------------
interface pixel_ram_loader_if;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_address;
    logic [3:0] wr_data;
    logic [3:0] address;
    logic [3:0] data;
    logic       busy;
    logic       done;
    logic [4:0] count;

    modport slave (
        input  start, in_valid, in_data, wr_en, wr_address, wr_data, address,
        output in_ready, data, busy, done, count
    );

    modport master (
        output start, in_valid, in_data, wr_en, wr_address, wr_data, address,
        input  in_ready, data, busy, done, count
    );
endinterface

// File: rtl/pixel_ram_loader.sv
// -----------------------------------------------------------------------------
// pixel_ram_loader
// Writable 16-entry x 4-bit pixel store for the 4x4 convolution datapath.
// A frame of 16 pixels is streamed in over valid/ready and stored at addresses
// 0..15 in raster order. The convolution core reads through a combinational
// address/data port identical to the pixel ROM. A random-access write port
// patches a frame while the store is idle or full.
// Ports:
//   i_clk   clock, all state updates on the rising edge
//   i_clr   asynchronous active-high reset; clears memory, state and outputs
//   io_bus  pixel_ram_loader_if.slave (stream, write, read and status signals)
// -----------------------------------------------------------------------------
module pixel_ram_loader (
    input  logic                  i_clk,
    input  logic                  i_clr,
    pixel_ram_loader_if.slave     io_bus
);

    localparam int DEPTH = 16;
    localparam int WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_ptr;
    logic [4:0]       r_count;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_ptr_nxt;
    logic [4:0]       w_count_nxt;
    logic             w_we;
    logic [3:0]       w_waddr;
    logic [WIDTH-1:0] w_wdata;

    // Next-state, pointer/count and the single memory write port selection.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_we        = 1'b0;
        w_waddr     = 4'd0;
        w_wdata     = 4'd0;
        case (r_state)
            ST_IDLE, ST_FULL: begin
                // Random-access writes are honoured even when start is also
                // asserted; the new frame then begins on the next edge.
                if (io_bus.wr_en) begin
                    w_we    = 1'b1;
                    w_waddr = io_bus.wr_address;
                    w_wdata = io_bus.wr_data;
                end else begin
                    w_we    = 1'b0;
                end
                if (io_bus.start) begin
                    w_state_nxt = ST_LOAD;
                    w_ptr_nxt   = 4'd0;
                    w_count_nxt = 5'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LOAD: begin
                // Restart wins over a beat presented in the same cycle: the
                // beat is dropped. wr_en is ignored while the stream owns
                // the memory.
                if (io_bus.start) begin
                    w_ptr_nxt   = 4'd0;
                    w_count_nxt = 5'd0;
                end else if (io_bus.in_valid && r_in_ready) begin
                    w_we    = 1'b1;
                    w_waddr = r_ptr;
                    w_wdata = io_bus.in_data;
                    if (r_ptr == 4'd15) begin
                        w_state_nxt = ST_FULL;
                        w_ptr_nxt   = 4'd0;
                        w_count_nxt = 5'd16;
                    end else begin
                        w_ptr_nxt   = r_ptr + 4'd1;
                        w_count_nxt = r_count + 5'd1;
                    end
                end else begin
                    w_ptr_nxt   = r_ptr;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = 4'd0;
                w_count_nxt = 5'd0;
            end
        endcase
    end

    // State, pointer, count and status flags. The flags are registered from
    // the next state so they depend on flops only, never on live inputs.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 4'd0;
            r_count    <= 5'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_state_nxt == ST_LOAD);
            r_busy     <= (w_state_nxt == ST_LOAD);
            r_done     <= (w_state_nxt == ST_FULL);
        end
    end

    // Pixel storage; cleared asynchronously so data reads 0 while i_clr is held.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 4'd0;
            end
        end else if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end else begin
            r_mem[w_waddr] <= r_mem[w_waddr];
        end
    end

    assign io_bus.in_ready = r_in_ready;
    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.count    = r_count;
    assign io_bus.data     = r_mem[io_bus.address];

endmodule

// File: tb/tb_pixel_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_pixel_ram_loader
// Scoreboard bench: the driver applies one set of inputs per cycle, consults a
// behavioural frame model for what the store must show during that cycle and
// queues it; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_pixel_ram_loader;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    pixel_ram_loader_if bus ();

    pixel_ram_loader dut (
        .i_clk  (clk),
        .i_clr  (clr),
        .io_bus (bus)
    );

    typedef struct {
        logic [3:0] addr;
        logic [3:0] data;
        bit         rdy;
        bit         busy;
        bit         done;
        int         count;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Behavioural model: a frame is "loading" until 16 pixels have arrived.
    logic [3:0] m_mem [16];
    bit         m_loading;
    bit         m_full;
    int         m_ptr;
    int         m_count;

    logic [3:0] frame [16] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd1,
                               4'd3, 4'd2, 4'd3, 4'd2, 4'd3, 4'd3, 4'd3, 4'd1};

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 4'd0;
        m_loading = 1'b0;
        m_full    = 1'b0;
        m_ptr     = 0;
        m_count   = 0;
    endtask

    task automatic model_step(input bit s, input bit v, input logic [3:0] d,
                              input bit we, input logic [3:0] wa, input logic [3:0] wd);
        if (m_loading) begin
            if (s) begin
                m_ptr   = 0;
                m_count = 0;
            end else if (v) begin
                m_mem[m_ptr] = d;
                m_ptr++;
                m_count++;
                if (m_count == 16) begin
                    m_loading = 1'b0;
                    m_full    = 1'b1;
                    m_ptr     = 0;
                end
            end
        end else begin
            if (we) m_mem[wa] = wd;
            if (s) begin
                m_loading = 1'b1;
                m_full    = 1'b0;
                m_ptr     = 0;
                m_count   = 0;
            end
        end
    endtask

    // One cycle: called at posedge+1, returns at the next posedge+1.
    task automatic drive(input bit s, input bit v, input logic [3:0] d,
                         input bit we, input logic [3:0] wa, input logic [3:0] wd,
                         input logic [3:0] ra);
        exp_t e;
        bus.start      = s;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.wr_en      = we;
        bus.wr_address = wa;
        bus.wr_data    = wd;
        bus.address    = ra;
        e.addr  = ra;
        e.data  = m_mem[ra];
        e.rdy   = m_loading;
        e.busy  = m_loading;
        e.done  = m_full;
        e.count = m_count;
        sb_q.push_back(e);
        @(posedge clk);
        model_step(s, v, d, we, wa, wd);
        #1;
    endtask

    task automatic idle(input logic [3:0] ra);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, ra);
    endtask

    task automatic readback();
        for (int i = 0; i < 16; i++) idle(4'(i));
    endtask

    // Asynchronous-clear checks: flags and every address read zero with CLR held.
    task automatic check_cleared(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_busy"},     bus.busy,     0);
        check({tag, "_done"},     bus.done,     0);
        check({tag, "_count"},    bus.count,    0);
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1;
            check($sformatf("%s_data[%0d]", tag, a), bus.data, 0);
        end
    endtask

    // Monitor: compare what the store presents against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("in_ready", bus.in_ready, e.rdy);
                check("busy",     bus.busy,     e.busy);
                check("done",     bus.done,     e.done);
                check("count",    bus.count,    e.count);
                check($sformatf("data[%0d]", e.addr), bus.data, e.data);
            end
        end
    end

    initial begin
        clr            = 1'b1;
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 4'd0;
        bus.wr_en      = 1'b0;
        bus.wr_address = 4'd0;
        bus.wr_data    = 4'd0;
        bus.address    = 4'd0;
        model_reset();
        #2;
        check_cleared("por");
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back frame, then read every address back.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, frame[i], 1'b0, 4'd0, 4'd0, 4'($urandom));
        check("done_after_17", bus.done, 1);
        readback();

        // Random write while FULL, visible next cycle.
        drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd9, 4'd5);
        idle(4'd5);

        // Bubbled frame; writes to address 15 during bubbles must be ignored.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 4'(i), 4'd15);
            drive(1'b0, 1'b1, frame[i], 1'b0, 4'd0, 4'd0, 4'd15);
        end
        readback();

        // Restart after 5 beats with a beat of 7 in the same cycle.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b1, 4'(10 + i), 1'b0, 4'd0, 4'd0, 4'd0);
        drive(1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd0, 4'd0);
        idle(4'd0);
        for (int i = 1; i < 16; i++)
            drive(1'b0, 1'b1, 4'($urandom), 1'b0, 4'd0, 4'd0, 4'($urandom));
        readback();

        // Randomized traffic.
        repeat (400)
            drive(($urandom % 20) == 0, ($urandom % 4) != 0, 4'($urandom),
                  ($urandom % 4) == 0, 4'($urandom), 4'($urandom), 4'($urandom));

        // Clear in the middle of a load.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 4'($urandom_range(15, 1)), 1'b0, 4'd0, 4'd0, 4'd0);
        clr = 1'b1;
        model_reset();
        #1;
        check_cleared("midclr");
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 4'd0, 4'(i));
        drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, 4'($urandom), 1'b0, 4'd0, 4'd0, 4'($urandom));
        readback();

        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
